frog_move: RTL and testbench

Frog motion controller for the VGA game layer: owns the frog sprite's top-left position and drives `ObjectStartX`/`ObjectStartY` into the frog sprite renderer. It converts debounced key presses into fixed-size animated hops, handles screen-edge limits and collision deaths, and reports top-of-screen arrivals. It is the writer side of the sprite-position interface: the renderer only reads these coordinates, and this block is their sole producer.

---
 rtl/frog_pkg.sv | 22 ++
 rtl/frog_key_sync.sv | 38 +++
 rtl/frog_move.sv | 219 +++++++++++++++++++++
 tb/tb_frog_move.sv | 376 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/frog_pkg.sv
// Shared types and constants for the frog game layer: FSM states, hop
// directions, screen geometry and the key-edge priority encoder.
package frog_pkg;

   localparam int SCREEN_W    = 640;
   localparam int SCREEN_H    = 480;
   localparam int SPRITE_SIZE = 26;

   typedef enum logic [1:0] {IDLE, HOP, DEAD} state_t;

   typedef enum logic [2:0] {DIR_NONE, DIR_UP, DIR_DOWN, DIR_LEFT, DIR_RIGHT} dir_t;

   // Edge vector bit order is {right, left, down, up}; up wins ties.
   function automatic dir_t pick_dir(input logic [3:0] edges);
      if (edges[0]) return DIR_UP;
      if (edges[1]) return DIR_DOWN;
      if (edges[2]) return DIR_LEFT;
      if (edges[3]) return DIR_RIGHT;
      return DIR_NONE;
   endfunction

endpackage

// File: rtl/frog_key_sync.sv
// Four-bit two-flop synchroniser followed by a registered rising-edge detector;
// a key edge appears on key_edge three cycles after the raw input rises.
module frog_key_sync (
   input  logic       CLK,
   input  logic       RESETn,
   input  logic [3:0] keys_in,
   output logic [3:0] key_edge
);

   logic [3:0] meta_q, meta_d;
   logic [3:0] sync_q, sync_d;
   logic [3:0] prev_q, prev_d;
   logic [3:0] edge_q, edge_d;

   always_comb begin
      meta_d = keys_in;
      sync_d = meta_q;
      prev_d = sync_q;
      edge_d = sync_q & ~prev_q;
   end

   always_ff @(posedge CLK or negedge RESETn) begin
      if (!RESETn) begin
         meta_q <= '0;
         sync_q <= '0;
         prev_q <= '0;
         edge_q <= '0;
      end else begin
         meta_q <= meta_d;
         sync_q <= sync_d;
         prev_q <= prev_d;
         edge_q <= edge_d;
      end
   end

   assign key_edge = edge_q;

endmodule

// File: rtl/frog_move.sv
// Frog sprite position controller: key-driven animated hops, screen-edge limits,
// collision deaths and top-of-screen arrival. Define FROG_CARRY_EN for log drift.
module frog_move
   import frog_pkg::*;
#(
   parameter int INIT_X      = 307,
   parameter int INIT_Y      = 454,
   parameter int MAX_X       = 614,
   parameter int MAX_Y       = 454,
   parameter int STEP        = 26,
   parameter int SPEED       = 2,
   parameter int DEAD_FRAMES = 60
) (
   input  logic        CLK,
   input  logic        RESETn,
   input  logic        startOfFrame,
   input  logic        key_up,
   input  logic        key_down,
   input  logic        key_left,
   input  logic        key_right,
   input  logic        collision,
   input  logic [3:0]  carry_dx,
   output logic [10:0] ObjectStartX,
   output logic [10:0] ObjectStartY,
   output logic        hopping,
   output logic        dead,
   output logic        reached_top
);

   localparam int DW = $clog2(DEAD_FRAMES + 1);
   localparam logic [10:0] INIT_X_C = 11'(INIT_X);
   localparam logic [10:0] INIT_Y_C = 11'(INIT_Y);
   localparam logic [10:0] MAX_X_C  = 11'(MAX_X);
   localparam logic [10:0] STEP_C   = 11'(STEP);
   localparam logic [10:0] SPEED_C  = 11'(SPEED);
   localparam logic signed [11:0] STEP_S  = 12'(STEP);
   localparam logic signed [11:0] MAX_X_S = 12'(MAX_X);
   localparam logic signed [11:0] MAX_Y_S = 12'(MAX_Y);

   state_t         state_q, state_d;
   dir_t           pend_q, pend_d;
   dir_t           hdir_q, hdir_d;
   dir_t           new_dir;
   logic [10:0]    x_q, x_d, y_q, y_d;
   logic [10:0]    rem_q, rem_d;
   logic [10:0]    mv;
   logic [DW-1:0]  dcnt_q, dcnt_d;
   logic           hopping_q, hopping_d;
   logic           dead_q, dead_d;
   logic           top_q, top_d;
   logic [3:0]     key_edge;
   logic signed [11:0] x_s, y_s, tgt;
   logic           tgt_ok, start_hop;
   logic [10:0]    x_carry;

   frog_key_sync u_key_sync (
      .CLK      (CLK),
      .RESETn   (RESETn),
      .keys_in  ({key_right, key_left, key_down, key_up}),
      .key_edge (key_edge)
   );

   // Target of the pending hop, checked against [0, MAX] in signed arithmetic.
   always_comb begin
      x_s    = $signed({1'b0, x_q});
      y_s    = $signed({1'b0, y_q});
      tgt    = '0;
      tgt_ok = 1'b0;
      case (pend_q)
         DIR_UP: begin
            tgt    = y_s - STEP_S;
            tgt_ok = (tgt >= 12'sd0);
         end
         DIR_DOWN: begin
            tgt    = y_s + STEP_S;
            tgt_ok = (tgt <= MAX_Y_S);
         end
         DIR_LEFT: begin
            tgt    = x_s - STEP_S;
            tgt_ok = (tgt >= 12'sd0);
         end
         DIR_RIGHT: begin
            tgt    = x_s + STEP_S;
            tgt_ok = (tgt <= MAX_X_S);
         end
         default: ;
      endcase
   end

   assign start_hop = (pend_q != DIR_NONE) && tgt_ok;

`ifdef FROG_CARRY_EN
   logic signed [11:0] cx;

   always_comb begin
      cx = x_s + $signed({{8{carry_dx[3]}}, carry_dx});
      if (cx < 12'sd0)
         x_carry = '0;
      else if (cx > MAX_X_S)
         x_carry = MAX_X_C;
      else
         x_carry = cx[10:0];
   end
`else
   logic unused_carry;
   assign unused_carry = ^carry_dx;

   always_comb x_carry = x_q;
`endif

   assign mv = (rem_q < SPEED_C) ? rem_q : SPEED_C;

   always_comb begin
      state_d = state_q;
      x_d     = x_q;
      y_d     = y_q;
      rem_d   = rem_q;
      hdir_d  = hdir_q;
      dcnt_d  = dcnt_q;
      top_d   = 1'b0;
      new_dir = pick_dir(key_edge);
      pend_d  = (new_dir != DIR_NONE) ? new_dir : pend_q;

      case (state_q)
         IDLE: begin
            if (collision) begin
               state_d = DEAD;
               pend_d  = DIR_NONE;
               dcnt_d  = '0;
            end else if (startOfFrame) begin
               // A serviced or dropped request is consumed unless a newer edge arrives now.
               if (pend_q != DIR_NONE && new_dir == DIR_NONE)
                  pend_d = DIR_NONE;
               if (start_hop) begin
                  state_d = HOP;
                  hdir_d  = pend_q;
                  rem_d   = STEP_C;
               end else begin
                  x_d = x_carry;
               end
            end
         end
         HOP: begin
            if (collision) begin
               state_d = DEAD;
               pend_d  = DIR_NONE;
               dcnt_d  = '0;
            end else if (startOfFrame) begin
               rem_d = rem_q - mv;
               case (hdir_q)
                  DIR_UP:    y_d = y_q - mv;
                  DIR_DOWN:  y_d = y_q + mv;
                  DIR_LEFT:  x_d = x_q - mv;
                  DIR_RIGHT: x_d = x_q + mv;
                  default: ;
               endcase
               if (rem_d == '0) begin
                  state_d = IDLE;
                  if (y_d == '0) begin
                     top_d = 1'b1;
                     x_d   = INIT_X_C;
                     y_d   = INIT_Y_C;
                  end
               end
            end
         end
         DEAD: begin
            pend_d = DIR_NONE;
            if (startOfFrame) begin
               if (dcnt_q == DW'(DEAD_FRAMES - 1)) begin
                  state_d = IDLE;
                  dcnt_d  = '0;
                  x_d     = INIT_X_C;
                  y_d     = INIT_Y_C;
               end else begin
                  dcnt_d = dcnt_q + 1'b1;
               end
            end
         end
         default: state_d = IDLE;
      endcase

      hopping_d = (state_d == HOP);
      dead_d    = (state_d == DEAD);
   end

   always_ff @(posedge CLK or negedge RESETn) begin
      if (!RESETn) begin
         state_q   <= IDLE;
         pend_q    <= DIR_NONE;
         hdir_q    <= DIR_NONE;
         x_q       <= INIT_X_C;
         y_q       <= INIT_Y_C;
         rem_q     <= '0;
         dcnt_q    <= '0;
         hopping_q <= 1'b0;
         dead_q    <= 1'b0;
         top_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         pend_q    <= pend_d;
         hdir_q    <= hdir_d;
         x_q       <= x_d;
         y_q       <= y_d;
         rem_q     <= rem_d;
         dcnt_q    <= dcnt_d;
         hopping_q <= hopping_d;
         dead_q    <= dead_d;
         top_q     <= top_d;
      end
   end

   assign ObjectStartX = x_q;
   assign ObjectStartY = y_q;
   assign hopping      = hopping_q;
   assign dead         = dead_q;
   assign reached_top  = top_q;

endmodule

// File: tb/tb_frog_move.sv
// Self-checking bench for frog_move: table-driven hop sequences, hand-written
// corner cases and randomized stimulus against a queue-based reference model.
module tb_frog_move;

   localparam int FRAME  = 8;
   localparam int INIT_X = 307;
   localparam int INIT_Y = 454;
   localparam int MAX_X  = 614;
   localparam int MAX_Y  = 454;
   localparam int STEP   = 26;
   localparam int SPEED  = 2;
   localparam int DEADF  = 60;

   logic              CLK = 1'b0;
   logic              RESETn = 1'b0;
   logic              sof = 1'b0;
   logic              collision = 1'b0;
   logic [3:0]        keys = '0;
   logic signed [3:0] carry = '0;
   logic              key_up2 = 1'b0;
   logic [10:0]       ox, oy, x2, y2;
   logic              hopping, dead, top, hop2, dead2, top2;

   int   fcnt = 0;
   logic last_sof = 1'b0;
   int   n_checks = 0;
   int   n_err = 0;

   always #5 CLK = ~CLK;

   frog_move dut (
      .CLK          (CLK),
      .RESETn       (RESETn),
      .startOfFrame (sof),
      .key_up       (keys[0]),
      .key_down     (keys[1]),
      .key_left     (keys[2]),
      .key_right    (keys[3]),
      .collision    (collision),
      .carry_dx     (carry),
      .ObjectStartX (ox),
      .ObjectStartY (oy),
      .hopping      (hopping),
      .dead         (dead),
      .reached_top  (top)
   );

   // Second instance spawning at Y=52 so that two up hops land exactly on Y=0.
   frog_move #(.INIT_Y(52)) dut_top (
      .CLK          (CLK),
      .RESETn       (RESETn),
      .startOfFrame (sof),
      .key_up       (key_up2),
      .key_down     (1'b0),
      .key_left     (1'b0),
      .key_right    (1'b0),
      .collision    (1'b0),
      .carry_dx     (4'b0000),
      .ObjectStartX (x2),
      .ObjectStartY (y2),
      .hopping      (hop2),
      .dead         (dead2),
      .reached_top  (top2)
   );

   // ---------------- reference model ----------------
   int         m_x, m_y, m_pend, m_hdir, m_dead_left;
   bit         m_top;
   int         m_moves[$];
   logic [3:0] m_kh[4];

   function automatic int dir_of(input logic [3:0] e);
      if (e[0]) return 1;
      if (e[1]) return 2;
      if (e[2]) return 3;
      if (e[3]) return 4;
      return 0;
   endfunction

   task automatic model_reset();
      m_x = INIT_X; m_y = INIT_Y; m_pend = 0; m_hdir = 0; m_dead_left = 0; m_top = 0;
      m_moves.delete();
      for (int i = 0; i < 4; i++) m_kh[i] = '0;
   endtask

   task automatic model_step();
      logic [3:0] ev;
      int nd, d, tx, ty, r, s;
      bit started;
      ev = m_kh[2] & ~m_kh[3];
      m_kh[3] = m_kh[2]; m_kh[2] = m_kh[1]; m_kh[1] = m_kh[0]; m_kh[0] = keys;
      nd = dir_of(ev);
      m_top = 0;
      if (m_dead_left > 0) begin
         m_pend = 0;
         if (sof) begin
            m_dead_left--;
            if (m_dead_left == 0) begin m_x = INIT_X; m_y = INIT_Y; end
         end
      end else if (collision) begin
         m_dead_left = DEADF;
         m_moves.delete();
         m_pend = 0;
      end else if (m_moves.size() > 0) begin
         if (nd != 0) m_pend = nd;
         if (sof) begin
            d = m_moves.pop_front();
            case (m_hdir)
               1: m_y -= d;
               2: m_y += d;
               3: m_x -= d;
               default: m_x += d;
            endcase
            if (m_moves.size() == 0 && m_y == 0) begin
               m_top = 1; m_x = INIT_X; m_y = INIT_Y;
            end
         end
      end else begin
         started = 0;
         if (sof && m_pend != 0) begin
            tx = m_x; ty = m_y;
            case (m_pend)
               1: ty -= STEP;
               2: ty += STEP;
               3: tx -= STEP;
               default: tx += STEP;
            endcase
            if (tx >= 0 && tx <= MAX_X && ty >= 0 && ty <= MAX_Y) begin
               r = STEP;
               while (r > 0) begin
                  s = (r < SPEED) ? r : SPEED;
                  m_moves.push_back(s);
                  r -= s;
               end
               m_hdir = m_pend;
               started = 1;
            end
            m_pend = 0;
         end
         if (nd != 0) m_pend = nd;
`ifdef FROG_CARRY_EN
         if (sof && !started) begin
            tx = m_x + int'(carry);
            m_x = (tx < 0) ? 0 : (tx > MAX_X) ? MAX_X : tx;
         end
`endif
      end
   endtask

   task automatic compare_model();
      bit eh, ed;
      eh = (m_moves.size() > 0);
      ed = (m_dead_left > 0);
      n_checks++;
      if (ox !== 11'(m_x) || oy !== 11'(m_y) || hopping !== eh || dead !== ed || top !== m_top) begin
         n_err++;
         $display("FAIL model t=%0t: got x=%0d y=%0d hop=%0b dead=%0b top=%0b expected x=%0d y=%0d hop=%0b dead=%0b top=%0b",
                  $time, ox, oy, hopping, dead, top, m_x, m_y, eh, ed, m_top);
      end
   endtask

   // ---------------- helpers ----------------
   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic cycle();
      sof  = (fcnt == FRAME - 1);
      fcnt = (fcnt + 1) % FRAME;
      @(posedge CLK);
      last_sof = sof;
      #1;
      if (!RESETn) model_reset();
      else model_step();
      compare_model();
   endtask

   task automatic to_sof();
      for (int i = 0; i < FRAME; i++) begin
         cycle();
         if (last_sof) break;
      end
   endtask

   task automatic press(input logic [3:0] mask);
      keys = mask;
      repeat (4) cycle();
      keys = '0;
   endtask

   task automatic wait_hop(input int which);
      logic h;
      for (int i = 0; i < 3 * FRAME; i++) begin
         h = (which == 0) ? hopping : hop2;
         if (h) break;
         cycle();
      end
      h = (which == 0) ? hopping : hop2;
      check("hop_start", h, 1'b1);
   endtask

   task automatic do_reset();
      RESETn = 1'b0; keys = '0; key_up2 = 1'b0; collision = 1'b0; carry = '0;
      repeat (3) cycle();
      RESETn = 1'b1;
      cycle();
   endtask

   typedef struct {
      logic [3:0] key;
      int         reps;
      int         ex;
      int         ey;
   } vec_t;

   vec_t tbl[12];

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      tbl[0]  = '{4'b0001, 1,  307, 428};
      tbl[1]  = '{4'b1000, 1,  333, 428};
      tbl[2]  = '{4'b0100, 1,  307, 428};
      tbl[3]  = '{4'b0010, 1,  307, 454};
      tbl[4]  = '{4'b0010, 1,  307, 454};
      tbl[5]  = '{4'b0100, 11, 21,  454};
      tbl[6]  = '{4'b0100, 1,  21,  454};
      tbl[7]  = '{4'b1000, 2,  73,  454};
      tbl[8]  = '{4'b1000, 20, 593, 454};
      tbl[9]  = '{4'b1000, 1,  593, 454};
      tbl[10] = '{4'b0001, 17, 593, 12};
      tbl[11] = '{4'b0001, 1,  593, 12};

      // reset values
      RESETn = 1'b0;
      repeat (3) cycle();
      check("rst_x", ox, 307);
      check("rst_y", oy, 454);
      check("rst_flags", {hopping, dead, top}, 3'b000);
      check("rst_y2", y2, 52);
      RESETn = 1'b1;
      cycle();

      // table of hops including dropped requests at every edge
      for (int r = 0; r < 12; r++) begin
         for (int k = 0; k < tbl[r].reps; k++) begin
            press(tbl[r].key);
            repeat (15 * FRAME) cycle();
         end
         check($sformatf("tbl%0d_x", r), ox, tbl[r].ex);
         check($sformatf("tbl%0d_y", r), oy, tbl[r].ey);
         check($sformatf("tbl%0d_flags", r), {hopping, dead}, 2'b00);
      end

      // frame-by-frame up hop
      do_reset();
      press(4'b0001);
      wait_hop(0);
      for (int i = 1; i <= 13; i++) begin
         to_sof();
         check("hop_y", oy, 454 - 2 * i);
         check("hop_flag", hopping, (i < 13) ? 1 : 0);
      end
      check("hop_x", ox, 307);

      // collision mid-hop, keys ignored while dead
      do_reset();
      press(4'b0001);
      wait_hop(0);
      repeat (5) to_sof();
      cycle(); cycle();
      collision = 1'b1;
      cycle();
      collision = 1'b0;
      check("col_dead", dead, 1'b1);
      check("col_y", oy, 444);
      check("col_hop", hopping, 1'b0);
      press(4'b0001);
      for (int i = 1; i < 60; i++) to_sof();
      check("dead_hold", dead, 1'b1);
      check("dead_y", oy, 444);
      to_sof();
      check("respawn_x", ox, 307);
      check("respawn_y", oy, 454);
      check("respawn_dead", dead, 1'b0);
      repeat (3) to_sof();
      check("dead_key_ignored", {hopping, oy}, {1'b0, 11'd454});

      // top arrival on the Y=52 instance
      do_reset();
      key_up2 = 1'b1; repeat (4) cycle(); key_up2 = 1'b0;
      wait_hop(1);
      repeat (13) to_sof();
      check("top_mid_y", y2, 26);
      check("top_mid_pulse", top2, 1'b0);
      key_up2 = 1'b1; repeat (4) cycle(); key_up2 = 1'b0;
      wait_hop(1);
      repeat (12) to_sof();
      check("top_pre_y", y2, 2);
      to_sof();
      check("top_pulse", top2, 1'b1);
      check("top_x", x2, 307);
      check("top_y", y2, 52);
      check("top_hop", hop2, 1'b0);
      cycle();
      check("top_pulse_end", top2, 1'b0);

      // coincident up+right edges, right held
      do_reset();
      keys = 4'b1001;
      repeat (4) cycle();
      keys = 4'b1000;
      repeat (100) to_sof();
      check("coin_x", ox, 307);
      check("coin_y", oy, 428);
      keys = '0;
      cycle();

      // asynchronous reset mid-hop
      do_reset();
      press(4'b0001);
      wait_hop(0);
      repeat (3) to_sof();
      #2 RESETn = 1'b0;
      #1;
      check("async_y", oy, 454);
      check("async_hop", hopping, 1'b0);
      cycle();
      RESETn = 1'b1;
      cycle();

`ifdef FROG_CARRY_EN
      // carry drift clamped at the left edge
      do_reset();
      carry = -4'sd8;
      for (int i = 0; i < 60 && ox > 10; i++) to_sof();
      carry = -4'sd1;
      for (int i = 0; i < 20 && ox > 2; i++) to_sof();
      check("carry_setup", ox, 2);
      carry = -4'sd3;
      to_sof();
      check("carry_clamp", ox, 0);
      to_sof();
      check("carry_hold", ox, 0);
      carry = '0;
`endif

      // randomized stimulus against the model
      do_reset();
      for (int i = 0; i < 4000; i++) begin
         if ($urandom_range(15) == 0) begin
            int k;
            k = $urandom_range(3);
            keys[k] = ~keys[k];
         end
         collision = ($urandom_range(299) == 0);
         carry = 4'($urandom);
         cycle();
      end
      collision = 1'b0;
      keys = '0;
      carry = '0;

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
